// File: rtl/cache_pkg.sv
// Shared types, line geometry and address-field helpers for the L1 data cache.
package cache_pkg;

  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = 128;
  localparam int WORD_W     = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  // Helpers return 32-bit fields; callers narrow to their configured widths.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_bits);
    return addr >> (idx_bits + 2);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int idx_bits);
    return (addr >> 2) & ((32'd1 << idx_bits) - 32'd1);
  endfunction

  function automatic logic [1:0] addr_offset(input logic [31:0] addr);
    return addr[1:0];
  endfunction

endpackage

// File: rtl/cache_l1_array.sv
// Valid/tag/data storage for the direct-mapped L1: synchronous valid clear,
// whole-line refill write, single-word write and combinational lookup.
module cache_l1_array
  import cache_pkg::*;
#(
  parameter int IDX_BITS = 3,
  parameter int TAG_BITS = 30 - IDX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [LINE_W-1:0]   rd_line,
  input  logic                line_we,
  input  logic [IDX_BITS-1:0] line_idx,
  input  logic [TAG_BITS-1:0] line_tag,
  input  logic [LINE_W-1:0]   line_data,
  input  logic                word_we,
  input  logic [IDX_BITS-1:0] word_idx,
  input  logic [1:0]          word_off,
  input  logic [WORD_W-1:0]   word_data
);

  localparam int LINES = 2 ** IDX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_arr [LINES];
  logic [LINE_W-1:0]   data_arr [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (line_we) begin
      valid_q[line_idx] <= 1'b1;
    end
  end

  // Tag/data carry no reset: a line is only ever read through its valid bit.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_arr[line_idx]  <= line_tag;
      data_arr[line_idx] <= line_data;
    end else if (word_we) begin
      data_arr[word_idx][WORD_W*word_off +: WORD_W] <= word_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_arr[rd_idx];
  assign rd_line  = data_arr[rd_idx];

endmodule

// File: rtl/cache_level_1.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache (FSM and port muxing).
// Optional hit/miss counters are built when CACHE_L1_PERF_EN is defined.
//
// state  | meaning
// IDLE   | serve read hits, forward writes, detect read misses
// REFILL | CPU stalled, reading the missed line from L2 at miss_addr_q
module cache_level_1
  import cache_pkg::*;
#(
  parameter int IDX_BITS = 3,
  parameter int TAG_BITS = 30 - IDX_BITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  output logic          l2_read_index,
  output logic          l2_write_index,
  output logic [31:0]   l2_addr,
  output logic [31:0]   l2_write_data,
  input  logic          l2_stall,
`ifdef CACHE_L1_PERF_EN
  input  logic [127:0]  l2_block,
  output logic [31:0]   perf_hits,
  output logic [31:0]   perf_misses
`else
  input  logic [127:0]  l2_block
`endif
);

  state_t state_q, state_d;
  logic [31:0] miss_addr_q;

  logic [IDX_BITS-1:0] cur_idx, miss_idx;
  logic [TAG_BITS-1:0] cur_tag, miss_tag;
  logic [1:0]          cur_off;

  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [LINE_W-1:0]   rd_line;
  logic                hit;

  logic line_we, word_we, miss_latch, read_hit;

  assign cur_idx  = IDX_BITS'(addr_index(cpu_addr, IDX_BITS));
  assign cur_tag  = TAG_BITS'(addr_tag(cpu_addr, IDX_BITS));
  assign cur_off  = addr_offset(cpu_addr);
  assign miss_idx = IDX_BITS'(addr_index(miss_addr_q, IDX_BITS));
  assign miss_tag = TAG_BITS'(addr_tag(miss_addr_q, IDX_BITS));

  cache_l1_array #(
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (cur_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .line_we   (line_we),
    .line_idx  (miss_idx),
    .line_tag  (miss_tag),
    .line_data (l2_block),
    .word_we   (word_we),
    .word_idx  (cur_idx),
    .word_off  (cur_off),
    .word_data (cpu_wdata)
  );

  assign hit = rd_valid & (rd_tag == cur_tag);

  // Outputs and array writes are all forced low while rst is high.
  always_comb begin
    state_d        = state_q;
    cpu_rdata      = '0;
    cpu_stall      = 1'b0;
    l2_read_index  = 1'b0;
    l2_write_index = 1'b0;
    l2_addr        = '0;
    l2_write_data  = '0;
    line_we        = 1'b0;
    word_we        = 1'b0;
    miss_latch     = 1'b0;
    read_hit       = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (cpu_write) begin
            l2_write_index = 1'b1;
            l2_addr        = cpu_addr;
            l2_write_data  = cpu_wdata;
            word_we        = hit;
          end else if (cpu_read) begin
            if (hit) begin
              cpu_rdata = rd_line[WORD_W*cur_off +: WORD_W];
              read_hit  = 1'b1;
            end else begin
              cpu_stall  = 1'b1;
              miss_latch = 1'b1;
              state_d    = REFILL;
            end
          end
        end
        REFILL: begin
          cpu_stall     = 1'b1;
          l2_read_index = 1'b1;
          l2_addr       = miss_addr_q;
          if (!l2_stall) begin
            line_we = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_latch) begin
        miss_addr_q <= {cpu_addr[31:2], 2'b00};
      end
    end
  end

`ifdef CACHE_L1_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (read_hit && perf_hits != 32'hFFFF_FFFF) begin
        perf_hits <= perf_hits + 32'd1;
      end
      if (miss_latch && perf_misses != 32'hFFFF_FFFF) begin
        perf_misses <= perf_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_level_1.sv
// Directed bench for cache_level_1: refill timing, hits, write-through, conflicts, reset mid-refill.
module tb_cache_level_1;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_read, cpu_write;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_stall;
  logic         l2_read_index, l2_write_index;
  logic [31:0]  l2_addr, l2_write_data;
  logic         l2_stall;
  logic [127:0] l2_block;
`ifdef CACHE_L1_PERF_EN
  logic [31:0]  perf_hits, perf_misses;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  cache_level_1 dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_stall      (cpu_stall),
    .l2_read_index  (l2_read_index),
    .l2_write_index (l2_write_index),
    .l2_addr        (l2_addr),
    .l2_write_data  (l2_write_data),
    .l2_stall       (l2_stall),
`ifdef CACHE_L1_PERF_EN
    .l2_block       (l2_block),
    .perf_hits      (perf_hits),
    .perf_misses    (perf_misses)
`else
    .l2_block       (l2_block)
`endif
  );

  localparam logic [127:0] BLK_A = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
  localparam logic [127:0] BLK_E = {32'h4444_0203, 32'h3333_0202, 32'h2222_0201, 32'h1111_0200};
  localparam logic [127:0] BLK_F = {32'h6666_0063, 32'h6666_0062, 32'h6666_0061, 32'h6666_0060};
  localparam logic [127:0] BLK_G = {32'h7777_0023, 32'h7777_0022, 32'h7777_0021, 32'h7777_0020};
  localparam logic [127:0] BLK_H = {32'h8888_0083, 32'h8888_0082, 32'h8888_0081, 32'h8888_0080};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Read that must miss; L2 holds l2_stall for l2_wait REFILL cycles.
  // Ends in the first non-stalled cycle with cpu_read dropped before the edge.
  task automatic read_miss(input string tag, input logic [31:0] addr, input logic [127:0] blk,
                           input int l2_wait, input logic [31:0] exp_word);
    int n = 0;
    cpu_read  = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = addr;
    l2_block  = blk;
    for (int k = 0; k < 40; k++) begin
      l2_stall = (k >= 1 && k <= l2_wait);
      #2;
      if (!cpu_stall) break;
      n++;
      if (k == 1) begin
        chk({tag, "_l2_rd"}, l2_read_index, 1'b1);
        chk({tag, "_l2_addr"}, l2_addr, {addr[31:2], 2'b00});
      end
      @(posedge clk);
      #1;
    end
    chk({tag, "_stall_cycles"}, n, l2_wait + 2);
    chk({tag, "_rdata"}, cpu_rdata, exp_word);
    cpu_read = 1'b0;
    l2_stall = 1'b0;
  endtask

  task automatic read_hit(input string tag, input logic [31:0] addr, input logic [31:0] exp_word);
    cpu_read  = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = addr;
    #2;
    chk({tag, "_stall"}, cpu_stall, 1'b0);
    chk({tag, "_rdata"}, cpu_rdata, exp_word);
    cpu_read = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cpu_read = 1'b1; cpu_write = 1'b1;
    cpu_addr = 32'h40; cpu_wdata = 32'h1234_5678;
    l2_stall = 1'b0; l2_block = BLK_A;
    tick; tick;
    #2;
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_l2_rd", l2_read_index, 1'b0);
    chk("rst_l2_wr", l2_write_index, 1'b0);
    chk("rst_l2_addr", l2_addr, 32'h0);
    chk("rst_l2_wdata", l2_write_data, 32'h0);
    rst = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
    tick;

    // Cold miss: 1 IDLE + 3 held + 1 release = 5 stalled cycles
    read_miss("cold", 32'h40, BLK_A, 3, 32'hAAAA_0000);
    tick;
    read_hit("hit_43", 32'h43, 32'hDDDD_0003);
    tick;

    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = 32'h40;
    #2;
    chk("idle_rdata", cpu_rdata, 32'h0);
    chk("idle_stall", cpu_stall, 1'b0);
    chk("idle_l2_addr", l2_addr, 32'h0);
    chk("idle_l2_wr", l2_write_index, 1'b0);
    tick;

    cpu_write = 1'b1; cpu_addr = 32'h41; cpu_wdata = 32'hDEAD_BEEF;
    #2;
    chk("wh_l2_wr", l2_write_index, 1'b1);
    chk("wh_l2_addr", l2_addr, 32'h41);
    chk("wh_l2_wdata", l2_write_data, 32'hDEAD_BEEF);
    chk("wh_stall", cpu_stall, 1'b0);
    tick;
    cpu_write = 1'b0;
    read_hit("wh_rd41", 32'h41, 32'hDEAD_BEEF);
    tick;
    read_hit("wh_rd40", 32'h40, 32'hAAAA_0000);
    tick;

    cpu_write = 1'b1; cpu_addr = 32'h200; cpu_wdata = 32'h0BAD_F00D;
    #2;
    chk("wm_l2_wr", l2_write_index, 1'b1);
    chk("wm_l2_addr", l2_addr, 32'h200);
    chk("wm_stall", cpu_stall, 1'b0);
    tick;
    cpu_write = 1'b0;
    read_hit("wm_line_kept", 32'h42, 32'hCCCC_0002);
    tick;
    read_miss("wm_refill", 32'h200, BLK_E, 0, 32'h1111_0200);
    tick;

    // 0x200 evicted 0x40 from index 0; then 0x60 evicts it again
    read_miss("conf_40a", 32'h40, BLK_A, 1, 32'hAAAA_0000);
    tick;
    read_miss("conf_60", 32'h60, BLK_F, 2, 32'h6666_0060);
    tick;
    read_miss("conf_40b", 32'h42, BLK_A, 0, 32'hCCCC_0002);
    tick;

    // Read and write together behave as a write
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 32'h43; cpu_wdata = 32'h5555_AAAA;
    #2;
    chk("rw_stall", cpu_stall, 1'b0);
    chk("rw_l2_wr", l2_write_index, 1'b1);
    chk("rw_l2_rd", l2_read_index, 1'b0);
    tick;
    cpu_write = 1'b0;
    read_hit("rw_rd43", 32'h43, 32'h5555_AAAA);
    tick;

    // Address moves during REFILL; refill must still target the miss address
    cpu_read = 1'b1; cpu_addr = 32'h21; l2_block = BLK_G; l2_stall = 1'b0;
    #2;
    chk("mv_miss_stall", cpu_stall, 1'b1);
    tick;
    cpu_addr = 32'h5C;
    #2;
    chk("mv_l2_addr", l2_addr, 32'h20);
    tick;
    read_hit("mv_rd21", 32'h21, 32'h7777_0021);
    tick;

    // Reset in the second REFILL cycle
    cpu_read = 1'b1; cpu_addr = 32'h80; l2_block = BLK_H; l2_stall = 1'b1;
    tick;
    tick;
    rst = 1'b1; l2_stall = 1'b0;
    #2;
    chk("mr_l2_rd", l2_read_index, 1'b0);
    chk("mr_stall", cpu_stall, 1'b0);
    tick;
    rst = 1'b0; cpu_read = 1'b0;
    tick;
    read_miss("mr_reread", 32'h80, BLK_H, 0, 32'h8888_0080);
    tick;
    read_miss("mr_cleared", 32'h40, BLK_A, 0, 32'hAAAA_0000);
    tick;

`ifdef CACHE_L1_PERF_EN
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #2;
    chk("perf_rst_hits", perf_hits, 32'd0);
    tick;
    read_miss("perf_m1", 32'h40, BLK_A, 0, 32'hAAAA_0000);
    tick;
    read_hit("perf_h1", 32'h40, 32'hAAAA_0000);
    cpu_read = 1'b1;
    tick;
    read_hit("perf_h2", 32'h41, 32'hBBBB_0001);
    cpu_read = 1'b1;
    tick;
    read_miss("perf_m2", 32'h60, BLK_F, 0, 32'h6666_0060);
    tick;
    chk("perf_hits", perf_hits, 32'd2);
    chk("perf_misses", perf_misses, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
